// File: rtl/armleocpu_cache_permcheck.sv
// Registered page permission check between the cache TLB-read stage and the response path.
// Optionally turns A/D-only faults into a PTE A/D update transaction before responding.
module armleocpu_cache_permcheck #(
  parameter int ID_W         = 4,
  parameter int HW_AD_UPDATE = 0
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ID_W-1:0] req_id,
  input  logic [3:0]      req_cmd,
  input  logic [7:0]      req_accesstag,

  input  logic            csr_satp_mode,
  input  logic [1:0]      csr_mcurrent_privilege,
  input  logic            csr_mstatus_mprv,
  input  logic            csr_mstatus_mxr,
  input  logic            csr_mstatus_sum,
  input  logic [1:0]      csr_mstatus_mpp,

  output logic            upd_valid,
  input  logic            upd_ready,
  output logic [ID_W-1:0] upd_id,
  output logic [7:0]      upd_accesstag,
  input  logic            upd_done,
  input  logic            upd_error,

  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [ID_W-1:0] resp_id,
  output logic            resp_pagefault,
  output logic [3:0]      resp_cause,
  output logic [7:0]      resp_accesstag
);

  localparam logic [3:0] CACHE_CMD_EXECUTE = 4'd1;
  localparam logic [3:0] CACHE_CMD_LOAD    = 4'd2;
  localparam logic [3:0] CACHE_CMD_STORE   = 4'd3;

  localparam logic [1:0] PRIV_USER    = 2'b00;
  localparam logic [1:0] PRIV_SUPER   = 2'b01;
  localparam logic [1:0] PRIV_MACHINE = 2'b11;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
  // a producer holds valid and its payload stable until that edge.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RESP     = 2'd1,
    S_UPD_REQ  = 2'd2,
    S_UPD_WAIT = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0] id_q;
  logic            pf_q;
  logic [3:0]      cause_q;
  logic [7:0]      tag_q;
  logic [7:0]      upd_tag_q;

  logic [1:0] eff_priv;
  logic       is_load, is_store, is_exec, bypass;
  logic       t_v, t_r, t_w, t_x, t_u, t_a, t_d;
  logic [3:0] chk_cause;
  logic       ad_only;
  logic [7:0] new_tag;
  logic       accept;

  always_comb begin
    eff_priv = (csr_mcurrent_privilege == PRIV_MACHINE && csr_mstatus_mprv)
             ? csr_mstatus_mpp : csr_mcurrent_privilege;
    is_load  = (req_cmd == CACHE_CMD_LOAD);
    is_store = (req_cmd == CACHE_CMD_STORE);
    is_exec  = (req_cmd == CACHE_CMD_EXECUTE);
    bypass   = !csr_satp_mode || (eff_priv == PRIV_MACHINE) || !(is_load || is_store || is_exec);
    t_v = req_accesstag[0];
    t_r = req_accesstag[1];
    t_w = req_accesstag[2];
    t_x = req_accesstag[3];
    t_u = req_accesstag[4];
    t_a = req_accesstag[6];
    t_d = req_accesstag[7];
    chk_cause = 4'd0;
    if (!bypass) begin
      if (!t_v || !(t_r || t_x))                             chk_cause = 4'd1;
      else if (eff_priv == PRIV_SUPER && t_u && !csr_mstatus_sum) chk_cause = 4'd2;
      else if (eff_priv == PRIV_USER && !t_u)                chk_cause = 4'd3;
      else if (is_store && !t_w)                             chk_cause = 4'd6;
      else if (is_load && !t_r && !(csr_mstatus_mxr && t_x)) chk_cause = 4'd7;
      else if (is_exec && !t_x)                              chk_cause = 4'd8;
      else if (!t_a)                                         chk_cause = 4'd4;
      else if (is_store && !t_d)                             chk_cause = 4'd5;
    end
    ad_only = (HW_AD_UPDATE != 0) && (chk_cause == 4'd4 || chk_cause == 4'd5);
    new_tag = req_accesstag | 8'h40 | (is_store ? 8'h80 : 8'h00);
    accept  = (state_q == S_IDLE) && req_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (req_valid)  state_d = ad_only ? S_UPD_REQ : S_RESP;
      S_RESP:     if (resp_ready) state_d = S_IDLE;
      S_UPD_REQ:  if (upd_ready)  state_d = S_UPD_WAIT;
      S_UPD_WAIT: if (upd_done)   state_d = S_RESP;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    upd_valid  = 1'b0;
    case (state_q)
      S_IDLE:    req_ready  = 1'b1;
      S_RESP:    resp_valid = 1'b1;
      S_UPD_REQ: upd_valid  = 1'b1;
      default:   ;
    endcase
  end

  // The check result is latched at accept, so later CSR changes cannot alter it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q      <= '0;
      pf_q      <= 1'b0;
      cause_q   <= 4'd0;
      tag_q     <= 8'h00;
      upd_tag_q <= 8'h00;
    end else if (accept) begin
      id_q      <= req_id;
      pf_q      <= (chk_cause != 4'd0) && !ad_only;
      cause_q   <= ad_only ? 4'd0 : chk_cause;
      tag_q     <= req_accesstag;
      upd_tag_q <= new_tag;
    end else if (state_q == S_UPD_WAIT && upd_done) begin
      if (upd_error) begin
        pf_q    <= 1'b1;
        cause_q <= 4'd9;
      end else begin
        pf_q    <= 1'b0;
        cause_q <= 4'd0;
        tag_q   <= upd_tag_q;
      end
    end
  end

  assign upd_id         = id_q;
  assign upd_accesstag  = upd_tag_q;
  assign resp_id        = id_q;
  assign resp_pagefault = pf_q;
  assign resp_cause     = cause_q;
  assign resp_accesstag = tag_q;

endmodule

// File: doc/armleocpu_cache_permcheck.md
Name: armleocpu_cache_permcheck

Overview:
- Handshaked, registered successor to the combinational cache pagefault check.
- Sits between the cache TLB-read stage and the cache response path. Each request is checked against privilege and mstatus state, producing a fault flag plus an encoded cause.
- When HW_AD_UPDATE=1, a request that fails only because the A or D bit is clear is not faulted. The block issues a PTE A/D update transaction instead and responds after that update completes.

Parameters:
- ID_W, 4: width of the request tag passed through to the update and response channels.
- HW_AD_UPDATE, 0: 0 means a clear A, or a clear D on a store, faults. 1 means it triggers an update transaction.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request valid
- req_ready  output  1  block can accept a request
- req_id  input  ID_W  request tag
- req_cmd  input  4  CACHE_CMD_LOAD / CACHE_CMD_STORE / CACHE_CMD_EXECUTE; any other value is a bypass command
- req_accesstag  input  8  bit0 V, 1 R, 2 W, 3 X, 4 U, 5 G, 6 A, 7 D
- csr_satp_mode  input  1  0 = translation off
- csr_mcurrent_privilege  input  2  encoding: 00 user, 01 supervisor, 11 machine
- csr_mstatus_mprv, csr_mstatus_mxr, csr_mstatus_sum  input  1 each
- csr_mstatus_mpp  input  2  previous privilege
- upd_valid  output  1  A/D update request
- upd_ready  input  1  update request accepted
- upd_id  output  ID_W  tag of the request being updated
- upd_accesstag  output  8  new accesstag to write back
- upd_done  input  1  one-cycle pulse: update finished
- upd_error  input  1  qualified by upd_done; update failed
- resp_valid  output  1  result valid
- resp_ready  input  1  consumer accepts the result
- resp_id  output  ID_W  tag of the request
- resp_pagefault  output  1  access faults
- resp_cause  output  4  fault cause code (see below)
- resp_accesstag  output  8  final accesstag, including any A/D update

Behaviour:
- Reset (asynchronous, rst_n low, any state including mid-update): state IDLE. All outputs 0 except req_ready=1. Internal registers cleared.
- State machine: IDLE, RESP, UPD_REQ, UPD_WAIT.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture id, cmd, accesstag and all csr_* inputs.
  - Later CSR changes do not affect this request.
  - Next state is RESP or UPD_REQ, as decided by the check.
  - Latency from accept to resp_valid is 1 cycle when no update is needed.
- Effective privilege: mpp if (privilege==11 && mprv), else privilege.
- Bypass (cause 0, no fault, no update): satp_mode=0, or effective privilege machine, or cmd is not LOAD/STORE/EXECUTE.
- Fault checks are evaluated in priority order; the first hit sets the cause and pagefault=1:
  1. cause 1: !V or !(R||X).
  2. cause 2: supervisor && U && !sum.
  3. cause 3: user && !U.
  4. cause 6: STORE && !W.
  5. cause 7: LOAD && !R && !(mxr&&X).
  6. cause 8: EXECUTE && !X.
  7. cause 4: !A.
  8. cause 5: STORE && !D.
- HW_AD_UPDATE=1, only causes 4 or 5 hit:
  - Go to UPD_REQ.
  - upd_accesstag = tag | A | (STORE ? D : 0).
- UPD_REQ:
  - upd_valid=1 with id and accesstag held stable until upd_ready.
  - On handshake, go to UPD_WAIT; upd_valid drops the next cycle.
- UPD_WAIT:
  - Wait for upd_done; go to RESP.
  - If upd_error: pagefault=1, cause 9, resp_accesstag = original tag.
  - Otherwise: pagefault=0, cause 0, resp_accesstag = updated tag.
  - upd_done in any other state is ignored.
- RESP:
  - resp_valid=1 with resp_* held stable until resp_ready.
  - On handshake, return to IDLE; req_ready rises the following cycle, so there is no same-cycle back-to-back accept.
  - Maximum throughput is 1 request per 2 cycles.
- resp_accesstag equals the captured tag in all non-update cases.
- resp_* and upd_* outputs are registered; no combinational path exists from input to output.

Test Plan:
- Bypass: satp=0, user, LOAD, tag=8'h00 → one cycle after accept: resp_valid=1, pagefault=0, cause=0, resp_accesstag=8'h00.
- Privilege: supervisor, sum=0, tag=8'h53 (V,R,U,A), LOAD → cause 2. Same with sum=1 → pagefault=0. User with tag=8'h43 → cause 3.
- MXR/priority: user, LOAD, tag=8'h59 (V,X,U,A) with mxr=0 → cause 7; with mxr=1 → no fault. STORE, tag=8'h13 (V,R,U; W, A, D clear) → cause 6, not cause 4.
- HW_AD_UPDATE=0: user STORE, tag=8'h57 (V,R,W,U,A) → cause 5. Same with tag=8'h17 → cause 4.
- HW_AD_UPDATE=1: user STORE, tag=8'h17, upd_ready held low 3 cycles → upd_valid=1 with stable upd_accesstag=8'hD7. Then upd_done → resp pagefault=0, resp_accesstag=8'hD7. Repeat with upd_error=1 → cause 9, resp_accesstag=8'h17.
- Stall/reset: hold resp_ready=0 for 5 cycles, toggling the csr_* inputs → resp_* unchanged. Assert rst_n=0 during UPD_WAIT → immediate IDLE, upd_valid=0, resp_valid=0, req_ready=1; a later upd_done is ignored.
